// File: rtl/serial_cmd_sequencer_if.sv
// Handshake bundle between the script sequencer (master) and the serial-command DUT (slave).
// Carries the DUT reset, the command handshake and the in/out data handshakes.
`timescale 1ns/1ps
interface serial_cmd_sequencer_if #(
  parameter int WORD_W = 64,
  parameter int CMD_W  = 16
);
  logic              dut_rst;
  logic [CMD_W-1:0]  dut_cmd;
  logic              dut_cmd_hasAny;
  logic              dut_cmd_consume;
  logic [WORD_W-1:0] dut_in;
  logic              dut_in_isReady;
  logic              dut_in_canReceive;
  logic [WORD_W-1:0] dut_out;
  logic              dut_out_isReady;
  logic              dut_out_canReceive;

  modport master (
    output dut_rst,
    output dut_cmd, dut_cmd_hasAny,
    input  dut_cmd_consume,
    output dut_in, dut_in_isReady,
    input  dut_in_canReceive,
    input  dut_out, dut_out_isReady,
    output dut_out_canReceive
  );

  modport slave (
    input  dut_rst,
    input  dut_cmd, dut_cmd_hasAny,
    output dut_cmd_consume,
    input  dut_in, dut_in_isReady,
    output dut_in_canReceive,
    output dut_out, dut_out_isReady,
    input  dut_out_canReceive
  );
endinterface

// File: rtl/serial_cmd_sequencer.sv
// Script engine: fetches {op,arg} entries from a preloaded RAM and drives/checks a serial-command DUT.
// DUT strobes decode from registered state only; blocking ops time out and log errors.
`timescale 1ns/1ps
module serial_cmd_sequencer #(
  parameter int WORD_W       = 64,
  parameter int CMD_W        = 16,
  parameter int DEPTH        = 256,
  parameter int TIMEOUT      = 1023,
  parameter int STOP_ON_FAIL = 1,
  parameter int ERR_W        = 8,
  localparam int PC_W        = $clog2(DEPTH),
  localparam int ARG_W       = (WORD_W > CMD_W) ? WORD_W : CMD_W,
  localparam int LD_W        = 3 + ARG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_we,
  input  logic [PC_W-1:0]   ld_addr,
  input  logic [LD_W-1:0]   ld_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [PC_W-1:0]   fail_pc,
  output logic [2:0]        fail_code,
  output logic [WORD_W-1:0] fail_word,
  output logic [ERR_W-1:0]  err_count,
  serial_cmd_sequencer_if.master dut
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_END, OP_RST, OP_CMD, OP_SEND, OP_SEND_CANT, OP_RECV, OP_RECV_CANT, OP_WAIT
  } op_t;

  localparam logic [2:0]      CODE_MISMATCH = 3'd1;
  localparam logic [2:0]      CODE_CAN_RECV = 3'd2;
  localparam logic [2:0]      CODE_IS_READY = 3'd3;
  localparam logic [2:0]      CODE_TIMEOUT  = 3'd4;
  localparam logic [15:0]     TO_LAST       = 16'(TIMEOUT - 1);
  localparam logic [PC_W-1:0] PC_LAST       = PC_W'(DEPTH - 1);
  localparam bit              STOP          = (STOP_ON_FAIL != 0);

  logic [LD_W-1:0]  mem [DEPTH];
  op_t              ir_op;
  logic [ARG_W-1:0] ir_arg;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            advance;
  logic            start_run;
  logic            err;
  logic [2:0]      err_code;
  logic            exec;

  assign busy = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign done = (state_q == S_DONE);
  assign exec = (state_q == S_EXEC);

  // Script RAM is not reset; loads are locked out for the whole run.
  always_ff @(posedge clk) begin
    if (ld_we && !busy) begin
      mem[ld_addr] <= ld_data;
    end
    if (state_q == S_FETCH) begin
      ir_op  <= op_t'(mem[pc_q][LD_W-1 -: 3]);
      ir_arg <= mem[pc_q][ARG_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    advance   = 1'b0;
    start_run = 1'b0;
    err       = 1'b0;
    err_code  = 3'd0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_FETCH;
          pc_d      = '0;
          start_run = 1'b1;
        end
      end
      S_FETCH: begin
        state_d = S_EXEC;
        cnt_d   = '0;
      end
      S_EXEC: begin
        cnt_d = cnt_q + 16'd1;
        case (ir_op)
          OP_END: state_d = S_DONE;
          OP_RST: advance = (cnt_q == 16'd1);
          OP_CMD: begin
            if (dut.dut_cmd_consume) begin
              advance = 1'b1;
            end else if (cnt_q == TO_LAST) begin
              advance  = 1'b1;
              err      = 1'b1;
              err_code = CODE_TIMEOUT;
            end
          end
          OP_SEND: begin
            if (dut.dut_in_canReceive) begin
              advance = 1'b1;
            end else if (cnt_q == TO_LAST) begin
              advance  = 1'b1;
              err      = 1'b1;
              err_code = CODE_TIMEOUT;
            end
          end
          OP_SEND_CANT: begin
            advance = 1'b1;
            if (dut.dut_in_canReceive) begin
              err      = 1'b1;
              err_code = CODE_CAN_RECV;
            end
          end
          OP_RECV: begin
            if (dut.dut_out_isReady) begin
              advance = 1'b1;
              if (dut.dut_out != ir_arg[WORD_W-1:0]) begin
                err      = 1'b1;
                err_code = CODE_MISMATCH;
              end
            end else if (cnt_q == TO_LAST) begin
              advance  = 1'b1;
              err      = 1'b1;
              err_code = CODE_TIMEOUT;
            end
          end
          OP_RECV_CANT: begin
            advance = 1'b1;
            if (dut.dut_out_isReady) begin
              err      = 1'b1;
              err_code = CODE_IS_READY;
            end
          end
          OP_WAIT: advance = (cnt_q == ir_arg[15:0]);
          default: state_d = S_DONE;
        endcase
        // The last entry finishes the run instead of wrapping back to entry 0.
        if (advance) begin
          if ((err && STOP) || (pc_q == PC_LAST)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            pc_d    = pc_q + PC_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || start_run) begin
      fail      <= 1'b0;
      fail_pc   <= '0;
      fail_code <= 3'd0;
      fail_word <= '0;
      err_count <= '0;
    end else if (err) begin
      if (err_count != '1) begin
        err_count <= err_count + ERR_W'(1);
      end
      // Only the first error of a run is recorded in detail.
      if (!fail) begin
        fail      <= 1'b1;
        fail_pc   <= pc_q;
        fail_code <= err_code;
        fail_word <= (err_code == CODE_MISMATCH) ? dut.dut_out : '0;
      end
    end
  end

  assign dut.dut_rst            = exec && (ir_op == OP_RST);
  assign dut.dut_cmd_hasAny     = exec && (ir_op == OP_CMD);
  assign dut.dut_cmd            = dut.dut_cmd_hasAny ? ir_arg[CMD_W-1:0] : '0;
  assign dut.dut_in_isReady     = exec && (ir_op == OP_SEND);
  assign dut.dut_in             = dut.dut_in_isReady ? ir_arg[WORD_W-1:0] : '0;
  assign dut.dut_out_canReceive = exec && ((ir_op == OP_RECV) || (ir_op == OP_RECV_CANT));

endmodule

// File: tb/tb_serial_cmd_sequencer.sv
// Directed bench for serial_cmd_sequencer (DEPTH=8, TIMEOUT=15, continue-on-fail).
// DUT responses are held as static levels set per step.
`timescale 1ns/1ps
module tb_serial_cmd_sequencer;
  localparam int WORD_W = 64;
  localparam int CMD_W  = 16;
  localparam int DEPTH  = 8;
  localparam int PC_W   = 3;

  localparam logic [2:0] OP_END = 3'd0, OP_RST = 3'd1, OP_CMD = 3'd2, OP_SEND = 3'd3;
  localparam logic [2:0] OP_SEND_CANT = 3'd4, OP_RECV = 3'd5, OP_RECV_CANT = 3'd6, OP_WAIT = 3'd7;
  localparam logic [63:0] PAT_A5 = 64'hA5A5_A5A5_A5A5_A5A5;

  logic            clk = 1'b0;
  logic            rst;
  logic            ld_we;
  logic [PC_W-1:0] ld_addr;
  logic [66:0]     ld_data;
  logic            start;
  logic            busy, done, fail;
  logic [PC_W-1:0] fail_pc;
  logic [2:0]      fail_code;
  logic [63:0]     fail_word;
  logic [7:0]      err_count;

  int n_chk  = 0;
  int n_fail = 0;
  int rst_cyc, busy_cyc, has_cyc;
  logic [63:0] cmd_seen, in_seen;

  serial_cmd_sequencer_if #(.WORD_W(WORD_W), .CMD_W(CMD_W)) dif ();

  serial_cmd_sequencer #(
    .WORD_W(WORD_W), .CMD_W(CMD_W), .DEPTH(DEPTH), .TIMEOUT(15),
    .STOP_ON_FAIL(0), .ERR_W(8)
  ) u_dut (
    .clk(clk), .rst(rst), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .busy(busy), .done(done), .fail(fail), .fail_pc(fail_pc),
    .fail_code(fail_code), .fail_word(fail_word), .err_count(err_count), .dut(dif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input int a, input logic [2:0] op, input logic [63:0] arg);
    @(negedge clk);
    ld_we   = 1'b1;
    ld_addr = PC_W'(a);
    ld_data = {op, arg};
    @(negedge clk);
    ld_we   = 1'b0;
  endtask

  task automatic set_resp(input logic cons, input logic canr, input logic rdy, input logic [63:0] word);
    dif.dut_cmd_consume   = cons;
    dif.dut_in_canReceive = canr;
    dif.dut_out_isReady   = rdy;
    dif.dut_out           = word;
  endtask

  // Pulses start (optionally together with a script write) and samples strobes until done.
  task automatic run(input string tag, input bit with_ld, input int a,
                     input logic [2:0] op, input logic [63:0] arg);
    int k;
    rst_cyc = 0; busy_cyc = 0; has_cyc = 0; cmd_seen = '0; in_seen = '0;
    @(negedge clk);
    start = 1'b1;
    if (with_ld) begin
      ld_we = 1'b1; ld_addr = PC_W'(a); ld_data = {op, arg};
    end
    @(negedge clk);
    start = 1'b0;
    ld_we = 1'b0;
    k = 0;
    while (!done && k < 200) begin
      if (busy) busy_cyc++;
      if (dif.dut_rst) rst_cyc++;
      if (dif.dut_cmd_hasAny) begin has_cyc++; cmd_seen = 64'(dif.dut_cmd); end
      if (dif.dut_in_isReady) in_seen = dif.dut_in;
      @(negedge clk);
      k++;
    end
    chk({tag, "_done"}, done, 1'b1);
  endtask

  initial begin
    rst = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0;
    set_resp(1'b0, 1'b0, 1'b0, '0);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_status", {done, fail, fail_code, fail_pc, err_count}, '0);
    chk("rst_strobes", {dif.dut_rst, dif.dut_cmd_hasAny, dif.dut_in_isReady, dif.dut_out_canReceive}, '0);
    rst = 1'b0;

    // 1: passing script against an always-ready DUT returning the sent pattern
    load(0, OP_RST, '0);
    load(1, OP_CMD, 64'h0123);
    load(2, OP_SEND, PAT_A5);
    load(3, OP_RECV, PAT_A5);
    load(4, OP_END, '0);
    set_resp(1'b1, 1'b1, 1'b1, PAT_A5);
    run("t1", 1'b0, 0, OP_END, '0);
    chk("t1_fail", {fail, err_count}, '0);
    chk("t1_rst_cycles", rst_cyc, 2);
    chk("t1_cmd", cmd_seen, 64'h0123);
    chk("t1_in", in_seen, PAT_A5);
    chk("t1_busy_cycles", busy_cyc, 11);
    chk("t1_strobes_idle", {dif.dut_rst, dif.dut_cmd_hasAny, dif.dut_in_isReady}, '0);

    // 2: receive mismatch at entry 1
    load(0, OP_WAIT, '0);
    load(1, OP_RECV, 64'h1111);
    load(2, OP_END, '0);
    set_resp(1'b1, 1'b1, 1'b1, 64'h2222);
    run("t2", 1'b0, 0, OP_END, '0);
    chk("t2_fail", fail, 1'b1);
    chk("t2_code", fail_code, 3'd1);
    chk("t2_word", fail_word, 64'h2222);
    chk("t2_pc", fail_pc, 3'd1);
    chk("t2_err_count", err_count, 8'd1);

    // 3a: DUT accepts data where it must not; run continues past the error
    load(0, OP_SEND_CANT, '0);
    load(1, OP_CMD, 64'h0042);
    load(2, OP_END, '0);
    set_resp(1'b1, 1'b1, 1'b0, '0);
    run("t3a", 1'b0, 0, OP_END, '0);
    chk("t3a_code", fail_code, 3'd2);
    chk("t3a_pc", fail_pc, 3'd0);
    chk("t3a_err_count", err_count, 8'd1);
    chk("t3a_word_cleared", fail_word, '0);
    chk("t3a_later_cmd", cmd_seen, 64'h0042);

    // 3b: quiet SEND_CANT passes, RECV_CANT with data present fails
    load(1, OP_RECV_CANT, '0);
    set_resp(1'b0, 1'b0, 1'b1, '0);
    run("t3b", 1'b0, 0, OP_END, '0);
    chk("t3b_code", fail_code, 3'd3);
    chk("t3b_pc", fail_pc, 3'd1);
    chk("t3b_err_count", err_count, 8'd1);

    // 4: command never consumed, receive never ready -> two timeouts
    load(0, OP_CMD, 64'h0777);
    load(1, OP_RECV, 64'h9);
    load(2, OP_END, '0);
    set_resp(1'b0, 1'b0, 1'b0, '0);
    run("t4", 1'b0, 0, OP_END, '0);
    chk("t4_hasany_cycles", has_cyc, 15);
    chk("t4_code", fail_code, 3'd4);
    chk("t4_pc", fail_pc, 3'd0);
    chk("t4_err_count", err_count, 8'd2);
    chk("t4_hasany_low", dif.dut_cmd_hasAny, 1'b0);

    // 5: every entry a WAIT, no END; last entry written in the start cycle
    for (int i = 0; i < 7; i++) load(i, OP_WAIT, '0);
    run("t5", 1'b1, 7, OP_WAIT, 64'd2);
    chk("t5_busy_cycles", busy_cyc, 18);
    chk("t5_fail", {fail, err_count}, '0);
    repeat (3) @(negedge clk);
    chk("t5_no_wrap", {busy, done}, 2'b01);

    // 6: reset during a blocked SEND; a load while busy is dropped
    load(0, OP_SEND, 64'h5A);
    load(1, OP_END, '0);
    set_resp(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    ld_we = 1'b1; ld_addr = '0; ld_data = {OP_END, 64'h0};
    @(negedge clk); ld_we = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_waiting", {dif.dut_in_isReady, dif.dut_in}, {1'b1, 64'h5A});
    rst = 1'b1;
    @(negedge clk);
    chk("t6_abort_busy", {busy, done}, 2'b00);
    chk("t6_abort_in", {dif.dut_in_isReady, dif.dut_in}, '0);
    rst = 1'b0;
    set_resp(1'b0, 1'b1, 1'b0, '0);
    run("t6b", 1'b0, 0, OP_END, '0);
    chk("t6b_load_dropped", in_seen, 64'h5A);
    chk("t6b_fail", fail, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
